// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the runtime-programmable serial pattern detector.
package seq_det_pkg;

    typedef enum logic [1:0] {
        UNCFG = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2
    } state_t;

    // Width needed to hold values 0..value-1 (ceil(log2(value))).
    function automatic int clog2(input int unsigned value);
        int unsigned v;
        int          result;
        v      = (value > 0) ? value - 1 : 0;
        result = 0;
        while (v != 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/seq_det_shift.sv
// Bit history shift register with a fill counter that saturates at PATTERN_W.
// shift_hist/shift_fill expose the post-shift values so matches can be judged on them.
module seq_det_shift #(
    parameter int PATTERN_W = 4,
    parameter int FILL_W    = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 shift,
    input  logic                 din,
    output logic [PATTERN_W-1:0] hist,
    output logic [FILL_W-1:0]    fill,
    output logic [PATTERN_W-1:0] shift_hist,
    output logic [FILL_W-1:0]    shift_fill
);

    localparam logic [FILL_W-1:0] FULL = FILL_W'(PATTERN_W);

    always_comb begin
        shift_hist = {hist[PATTERN_W-2:0], din};
        shift_fill = (fill == FULL) ? fill : fill + FILL_W'(1);
    end

    // clear wins over shift so a non-overlapping match restarts from empty
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            hist <= '0;
            fill <= '0;
        end else if (shift) begin
            hist <= shift_hist;
            fill <= shift_fill;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Programmable serial pattern detector: masked compare against a runtime pattern,
// overlapping/non-overlapping modes, registered match pulse and saturating match counter.
module seq_detector_param #(
    parameter int PATTERN_W = 4,
    parameter int COUNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 overlap_en,
    input  logic                 cfg_load,
    input  logic [PATTERN_W-1:0] cfg_pattern,
    input  logic [PATTERN_W-1:0] cfg_mask,
    input  logic                 count_clr,
    input  logic                 x_valid,
    input  logic                 x,
    output logic                 y,
    output logic [COUNT_W-1:0]   match_count,
    output logic                 armed
);

    import seq_det_pkg::*;

    localparam int                FILL_W = clog2(PATTERN_W + 1);
    localparam logic [FILL_W-1:0] FULL   = FILL_W'(PATTERN_W);

    state_t                 state_q;
    state_t                 state_d;
    logic [PATTERN_W-1:0]   pattern_q;
    logic [PATTERN_W-1:0]   mask_q;
    logic [PATTERN_W-1:0]   hist;
    logic [PATTERN_W-1:0]   shift_hist;
    logic [FILL_W-1:0]      fill;
    logic [FILL_W-1:0]      shift_fill;
    logic                   consume;
    logic                   match;
    logic                   hist_clear;

    seq_det_shift #(
        .PATTERN_W (PATTERN_W),
        .FILL_W    (FILL_W)
    ) u_shift (
        .clk        (clk),
        .rst        (rst),
        .clear      (hist_clear),
        .shift      (consume),
        .din        (x),
        .hist       (hist),
        .fill       (fill),
        .shift_hist (shift_hist),
        .shift_fill (shift_fill)
    );

    always_comb begin
        state_d    = state_q;
        consume    = 1'b0;
        match      = 1'b0;
        hist_clear = 1'b0;
        if (cfg_load) begin
            state_d    = FILL;
            hist_clear = 1'b1;
        end else begin
            case (state_q)
                UNCFG: state_d = UNCFG;
                FILL, ARMED: begin
                    if (enable && x_valid) begin
                        consume = 1'b1;
                        match   = (shift_fill == FULL) &&
                                  (((shift_hist ^ pattern_q) & mask_q) == '0);
                        if (match && !overlap_en) begin
                            hist_clear = 1'b1;
                            state_d    = FILL;
                        end else if (shift_fill == FULL) begin
                            state_d = ARMED;
                        end else begin
                            state_d = FILL;
                        end
                    end
                end
                default: begin
                    state_d    = UNCFG;
                    hist_clear = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= UNCFG;
            pattern_q <= '0;
            mask_q    <= '0;
            y         <= 1'b0;
        end else begin
            state_q <= state_d;
            y       <= match;
            if (cfg_load) begin
                pattern_q <= cfg_pattern;
                mask_q    <= cfg_mask;
            end
        end
    end

    // count_clr beats a coincident match; the count then holds at all-ones
    always_ff @(posedge clk) begin
        if (rst || count_clr) begin
            match_count <= '0;
        end else if (match && (match_count != '1)) begin
            match_count <= match_count + COUNT_W'(1);
        end
    end

    assign armed = (state_q == ARMED);

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param against a queue-based reference model.
module tb_seq_detector_param;

    localparam int P    = 4;
    localparam int CW   = 2;
    localparam int CMAX = 3;

    logic          clk = 1'b0;
    logic          rst, enable, overlap_en, cfg_load, count_clr, x_valid, x;
    logic [P-1:0]  cfg_pattern, cfg_mask;
    logic          y;
    logic [CW-1:0] match_count;
    logic          armed;

    int checks = 0;
    int errors = 0;

    // reference model: the last consumed bits since the most recent clear
    bit           m_cfg;
    logic [P-1:0] m_pat, m_mask;
    bit           m_q[$];
    bit           m_y;
    int           m_count;

    seq_detector_param #(
        .PATTERN_W (P),
        .COUNT_W   (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .overlap_en  (overlap_en),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_mask    (cfg_mask),
        .count_clr   (count_clr),
        .x_valid     (x_valid),
        .x           (x),
        .y           (y),
        .match_count (match_count),
        .armed       (armed)
    );

    always #5 clk = ~clk;

    function automatic logic exp_armed();
        return (m_q.size() == P);
    endfunction

    task automatic step(input logic r, input logic en, input logic ov, input logic cl,
                        input logic cc, input logic xv, input logic xb,
                        input logic [P-1:0] pat, input logic [P-1:0] msk);
        bit hit;
        rst = r; enable = en; overlap_en = ov; cfg_load = cl; count_clr = cc;
        x_valid = xv; x = xb; cfg_pattern = pat; cfg_mask = msk;
        @(posedge clk);
        hit = 1'b0;
        if (r) begin
            m_cfg = 1'b0; m_pat = '0; m_mask = '0; m_q.delete(); m_count = 0;
        end else begin
            if (cl) begin
                m_cfg = 1'b1; m_pat = pat; m_mask = msk; m_q.delete();
            end else if (en && xv && m_cfg) begin
                m_q.push_back(xb);
                if (m_q.size() > P) void'(m_q.pop_front());
                if (m_q.size() == P) begin
                    hit = 1'b1;
                    for (int i = 0; i < P; i++)
                        if (m_mask[P-1-i] && (m_q[i] != m_pat[P-1-i])) hit = 1'b0;
                    if (hit && !ov) m_q.delete();
                end
            end
            if (cc) m_count = 0;
            else if (hit && m_count < CMAX) m_count++;
        end
        m_y = hit;
        #1;
    endtask

    task automatic test_reset();
        bit s[4] = '{0, 1, 0, 1};
        step(1, 0, 0, 0, 0, 0, 0, '0, '0);
        step(1, 1, 1, 0, 0, 1, 1, '0, '0);
        if (y !== 1'b0) begin errors++; $display("FAIL reset y: got %b expected 0", y); end
        if (match_count !== '0) begin errors++; $display("FAIL reset count: got %0d expected 0", match_count); end
        if (armed !== 1'b0) begin errors++; $display("FAIL reset armed: got %b expected 0", armed); end
        checks += 3;
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 1, 0, 0, 1, s[i], '0, '0);
            if (y !== 1'b0) begin errors++; $display("FAIL uncfg y bit%0d: got %b expected 0", i, y); end
            if (armed !== 1'b0) begin errors++; $display("FAIL uncfg armed bit%0d: got %b expected 0", i, armed); end
            if (match_count !== '0) begin errors++; $display("FAIL uncfg count bit%0d: got %0d expected 0", i, match_count); end
            checks += 3;
        end
    endtask

    task automatic test_overlap();
        bit s[6] = '{0, 1, 0, 1, 0, 1};
        step(0, 1, 1, 1, 1, 0, 0, 4'b0101, 4'b1111);
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 1, 0, 0, 1, s[i], 4'b0101, 4'b1111);
            if (y !== m_y || y !== (i == 3 || i == 5)) begin errors++; $display("FAIL overlap y bit%0d: got %b expected %b", i, y, m_y); end
            if (armed !== exp_armed()) begin errors++; $display("FAIL overlap armed bit%0d: got %b expected %b", i, armed, exp_armed()); end
            checks += 2;
        end
        if (match_count !== CW'(2)) begin errors++; $display("FAIL overlap count: got %0d expected 2", match_count); end
        checks++;
    endtask

    task automatic test_nonoverlap();
        bit s[6] = '{0, 1, 0, 1, 0, 1};
        step(0, 1, 0, 1, 1, 0, 0, 4'b0101, 4'b1111);
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 0, 0, 0, 1, s[i], 4'b0101, 4'b1111);
            if (y !== m_y || y !== (i == 3)) begin errors++; $display("FAIL nonoverlap y bit%0d: got %b expected %b", i, y, m_y); end
            if (armed !== exp_armed() || (i >= 3 && armed !== 1'b0)) begin errors++; $display("FAIL nonoverlap armed bit%0d: got %b expected %b", i, armed, exp_armed()); end
            checks += 2;
        end
        if (match_count !== CW'(1)) begin errors++; $display("FAIL nonoverlap count: got %0d expected 1", match_count); end
        checks++;
    endtask

    task automatic test_idle_gaps();
        bit s[13] = '{0, 1, 0, 1, 0, 0, 1, 1, 0, 1, 0, 1, 0};
        step(0, 1, 1, 1, 1, 0, 0, 4'b0101, 4'b1111);
        for (int i = 0; i < 13; i++) begin
            if (i == 10) begin
                for (int k = 0; k < 3; k++) begin
                    step(0, 1, 1, 0, 0, 0, k[0], 4'b0101, 4'b1111);
                    if (y !== 1'b0) begin errors++; $display("FAIL gap y idle%0d: got %b expected 0", k, y); end
                    if (armed !== exp_armed()) begin errors++; $display("FAIL gap armed idle%0d: got %b expected %b", k, armed, exp_armed()); end
                    checks += 2;
                end
            end
            step(0, 1, 1, 0, 0, 1, s[i], 4'b0101, 4'b1111);
            if (y !== m_y || y !== (i == 3 || i == 11)) begin errors++; $display("FAIL gap y bit%0d: got %b expected %b", i, y, m_y); end
            checks++;
        end
        if (match_count !== CW'(2)) begin errors++; $display("FAIL gap count: got %0d expected 2", match_count); end
        checks++;
    endtask

    task automatic test_cfg_collision();
        step(0, 1, 1, 1, 1, 0, 0, 4'b1001, 4'b1001);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 1, 0, 0, 1, 1, 4'b1001, 4'b1001);
            if (y !== m_y || y !== (i == 3)) begin errors++; $display("FAIL collide y bit%0d: got %b expected %b", i, y, m_y); end
            checks++;
        end
        step(0, 1, 1, 1, 0, 1, 1, 4'b1001, 4'b1001);
        if (armed !== 1'b0 || y !== 1'b0) begin errors++; $display("FAIL collide load: got armed=%b y=%b expected 0 0", armed, y); end
        if (match_count !== CW'(m_count) || match_count !== CW'(1)) begin errors++; $display("FAIL collide count: got %0d expected 1", match_count); end
        checks += 2;
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 1, 0, 0, 1, 1, 4'b1001, 4'b1001);
            if (armed !== exp_armed() || armed !== (i == 3)) begin errors++; $display("FAIL collide refill armed bit%0d: got %b expected %b", i, armed, exp_armed()); end
            if (y !== m_y) begin errors++; $display("FAIL collide refill y bit%0d: got %b expected %b", i, y, m_y); end
            checks += 2;
        end
    endtask

    task automatic test_saturate();
        step(0, 1, 1, 1, 1, 0, 0, 4'b0000, 4'b0000);
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 1, 0, 0, 1, 1'($urandom), 4'b0000, 4'b0000);
            if (y !== m_y || y !== (i >= 3)) begin errors++; $display("FAIL sat y bit%0d: got %b expected %b", i, y, m_y); end
            checks++;
        end
        if (match_count !== CW'(CMAX)) begin errors++; $display("FAIL sat count: got %0d expected %0d", match_count, CMAX); end
        checks++;
        step(0, 1, 1, 0, 1, 1, 0, 4'b0000, 4'b0000);
        if (y !== 1'b1 || match_count !== '0) begin errors++; $display("FAIL sat clr: got y=%b count=%0d expected y=1 count=0", y, match_count); end
        checks++;
        step(0, 1, 1, 0, 0, 1, 1, 4'b0000, 4'b0000);
        step(1, 1, 1, 0, 0, 1, 1, 4'b0000, 4'b0000);
        if (y !== 1'b0 || match_count !== '0 || armed !== 1'b0) begin errors++; $display("FAIL midrst: got y=%b count=%0d armed=%b expected 0 0 0", y, match_count, armed); end
        checks++;
    endtask

    task automatic test_enable_freeze();
        logic [P-1:0] pat;
        logic         en;
        pat = P'($urandom);
        step(0, 1, 1, 1, 1, 0, 0, pat, 4'b1111);
        for (int i = 0; i < 200; i++) begin
            en = ($urandom_range(0, 2) != 0);
            step(0, en, 1, 0, 0, 1, 1'($urandom_range(0, 1)), pat, 4'b1111);
            if (y !== m_y || (!en && y !== 1'b0)) begin errors++; $display("FAIL enable y cyc%0d: got %b expected %b", i, y, m_y); end
            if (armed !== exp_armed()) begin errors++; $display("FAIL enable armed cyc%0d: got %b expected %b", i, armed, exp_armed()); end
            if (match_count !== CW'(m_count)) begin errors++; $display("FAIL enable count cyc%0d: got %0d expected %0d", i, match_count, m_count); end
            checks += 3;
        end
    endtask

    task automatic test_random();
        logic [P-1:0] pat, msk;
        logic         ov;
        ov  = 1'b1;
        pat = P'($urandom);
        msk = P'($urandom);
        step(0, 1, ov, 1, 1, 0, 0, pat, msk);
        for (int i = 0; i < 2000; i++) begin
            logic r, cl, cc;
            r  = ($urandom_range(0, 299) == 0);
            cl = ($urandom_range(0, 39) == 0) || (r == 1'b0 && !m_cfg);
            cc = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 15) == 0) ov = ~ov;
            if (cl) begin pat = P'($urandom); msk = P'($urandom); end
            step(r, ($urandom_range(0, 7) != 0), ov, cl, cc, ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), pat, msk);
            if (y !== m_y) begin errors++; $display("FAIL random y cyc%0d: got %b expected %b", i, y, m_y); end
            if (armed !== exp_armed()) begin errors++; $display("FAIL random armed cyc%0d: got %b expected %b", i, armed, exp_armed()); end
            if (match_count !== CW'(m_count)) begin errors++; $display("FAIL random count cyc%0d: got %0d expected %0d", i, match_count, m_count); end
            checks += 3;
        end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_idle_gaps();
        test_cfg_collision();
        test_saturate();
        test_enable_freeze();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Runtime-programmable serial bit-pattern detector; generalises the team's fixed single-pattern Mealy detector FSM.
- Pattern width is a parameter; pattern and per-bit compare mask are loaded at runtime.
- Selectable overlapping or non-overlapping match mode; qualified input strobe; saturating match counter.
- Sits behind a serial bit source in the crypto datapath; used for framing/sync-word detection.

Parameters:
- PATTERN_W, 4, pattern length in bits, legal range 2..32.
- COUNT_W, 8, width of saturating match counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  1 = consume x_valid bits; 0 = freeze all state, y forced 0.
- overlap_en  in  1  1 = overlapping matches; 0 = history restarts after each match.
- cfg_load  in  1  one-cycle strobe: latch cfg_pattern/cfg_mask, clear history.
- cfg_pattern  in  PATTERN_W  pattern; MSB = first bit received.
- cfg_mask  in  PATTERN_W  1 = compare this bit, 0 = don't care.
- count_clr  in  1  synchronous clear of match_count.
- x_valid  in  1  x is sampled this cycle.
- x  in  1  serial data bit.
- y  out  1  registered one-cycle match pulse.
- match_count  out  COUNT_W  matches since reset/count_clr; saturates at all-ones.
- armed  out  1  state == ARMED (history holds PATTERN_W valid bits).

Behaviour:
- Reset (rst=1 at edge): state UNCFG, pattern/mask/history 0, fill 0, y 0, match_count 0, armed 0. Reset has priority over all inputs.
- States:
  - UNCFG: ignores x_valid. cfg_load -> FILL.
  - FILL: fill < PATTERN_W.
  - ARMED: fill == PATTERN_W.
- Bit consume (state != UNCFG, enable=1, x_valid=1, cfg_load=0):
  - hist <= {hist[PATTERN_W-2:0], x}.
  - fill <= min(fill+1, PATTERN_W).
  - FILL -> ARMED when fill reaches PATTERN_W.
- Match condition: new_fill == PATTERN_W and ((new_hist ^ pattern) & mask) == 0.
  - Evaluated on post-shift values; registered into y at the same edge.
  - Latency: y is high for exactly the cycle after the edge that sampled the completing bit.
  - y is 0 in every cycle following an edge with no consumed bit.
- overlap_en=0 and match: fill <= 0, hist <= 0, state -> FILL. The next match needs PATTERN_W fresh bits.
- overlap_en=1 and match: remain ARMED.
- overlap_en is sampled per consumed bit; a change takes effect on the next bit.
- cfg_load (any state except reset):
  - pattern/mask latched, hist/fill cleared, state -> FILL, y <= 0.
  - match_count unchanged.
  - A simultaneous x_valid bit is dropped.
- enable=0: hist/fill/state held, y <= 0. cfg_load, count_clr and rst still act.
- match_count: +1 per match, holds at 2^COUNT_W-1. If count_clr and a match occur at the same edge, clear wins (count = 0) and y still pulses.
- mask all zeros: every consumed bit matches once ARMED (overlap), or once every PATTERN_W bits (non-overlap).
- x_valid gaps: no timeout. History persists across idle cycles of any length.

Decomposition:
- Package seq_det_pkg holds:
  - state encoding UNCFG=2'd0, FILL=2'd1, ARMED=2'd2 (2'd3 illegal; recovers to UNCFG).
  - function clog2 for fill counter width ($clog2(PATTERN_W+1)).
- One sub-module, seq_det_shift: history register plus saturating fill counter, with shift/clear inputs.
- FSM, compare and counter stay in the top module.

Test Plan:
- Reset then no cfg_load; stream 0101 with x_valid=1 -> y never asserts, armed=0, match_count=0.
- Load 0101, mask 1111, overlap_en=1; stream 0,1,0,1,0,1 -> y pulses the cycle after bit 3 and after bit 5; match_count=2.
- Same load, overlap_en=0, same stream -> single y pulse after bit 3; armed=0 after the match; match_count=1.
- Load 0101, mask 1111, overlap_en=1; stream 0,1,0,1,0,0,1,1,0,1,0,1,0 with x_valid deasserted for 3 idle cycles between bits 9 and 10 -> pulses after bits 3 and 11 only; count=2.
- Load 1001, mask 1001; stream 1,1,1,1 -> match after bit 3; then cfg_load asserted in the same cycle as x_valid -> bit dropped, fill=0, count unchanged.
- COUNT_W=2, all-zero mask, overlap_en=1, 6 bits -> count saturates at 3; count_clr coincident with a match -> count=0, y=1. Mid-stream rst -> all outputs 0 on the next cycle.
